// File: rtl/jk_drive_ctrl.sv
// jk_drive_ctrl: buffers JK/SR/T/D commands, drives a JK flop one cycle per command,
// and tracks a shadow Q to flag feedback mismatches.
module jk_drive_ctrl #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_mode,
  input  logic             cmd_a,
  input  logic             cmd_b,
  output logic             J,
  output logic             K,
  input  logic             q_fb,
  output logic             q_model,
  output logic             busy,
  output logic             illegal_sr,
  output logic             mismatch,
  output logic [CNT_W-1:0] err_cnt
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {SYNC, IDLE, DRIVE, CHECK} state_t;
  state_t           state_q;
  logic [3:0]       mem_q [DEPTH];
  logic [AW:0]      wp_q, rp_q;
  logic             j_q, k_q, q_q, ill_q, mis_q;
  logic [CNT_W-1:0] cnt_q;
  logic             empty, full, push, pop;
  logic [3:0]       head;
  logic             j_d, k_d, ill_d, q_d;
  assign empty      = wp_q == rp_q;
  assign full       = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign cmd_ready  = !full;
  assign push       = cmd_valid && !full;
  assign pop        = (state_q == IDLE) && !empty;
  assign head       = mem_q[rp_q[AW-1:0]];
  assign busy       = (state_q != IDLE) || !empty;
  assign J          = j_q;
  assign K          = k_q;
  assign q_model    = q_q;
  assign illegal_sr = ill_q;
  assign mismatch   = mis_q;
  assign err_cnt    = cnt_q;
  // head = {mode, a, b}; an SR command with S=R=1 degrades to a hold
  always_comb begin
    ill_d = (head[3:2] == 2'b01) && head[1] && head[0];
    j_d   = head[1] & ~ill_d;
    k_d   = (head[3:2] == 2'b10) ? head[1] :
            (head[3:2] == 2'b11) ? ~head[1] : head[0] & ~ill_d;
    q_d   = (j_q & ~q_q) | (~k_q & q_q);
  end
  always_ff @(posedge clk) if (push) mem_q[wp_q[AW-1:0]] <= {cmd_mode, cmd_a, cmd_b};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SYNC;
      wp_q    <= '0;
      rp_q    <= '0;
      j_q     <= 1'b0;
      k_q     <= 1'b0;
      q_q     <= 1'b0;
      ill_q   <= 1'b0;
      mis_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      if (push) wp_q <= wp_q + 1'b1;
      if (pop) rp_q <= rp_q + 1'b1;
      j_q   <= pop ? j_d : 1'b0;
      k_q   <= pop ? k_d : 1'b0;
      ill_q <= pop && ill_d;
      case (state_q)
        SYNC: begin
          q_q     <= q_fb;
          state_q <= IDLE;
        end
        IDLE: state_q <= pop ? DRIVE : IDLE;
        DRIVE: begin
          q_q     <= q_d;
          state_q <= CHECK;
        end
        default: begin
          if (q_fb != q_q) begin
            mis_q <= 1'b1;
            if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
          end
          state_q <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_jk_drive_ctrl.sv
// tb_jk_drive_ctrl: scoreboard bench with a behavioural JK flop closing the q_fb loop.
module tb_jk_drive_ctrl;
  logic       clk = 0, rst = 1, cmd_valid = 0, cmd_a = 0, cmd_b = 0;
  logic [1:0] cmd_mode = 0;
  logic       cmd_ready, J, K, q_model, busy, illegal_sr, mismatch;
  logic [7:0] err_cnt;
  logic       ff_q = 0, stuck = 0, q_fb;
  int         errors = 0, checks = 0;
  typedef struct packed {logic j, k, ill, q;} exp_t;
  exp_t       sb[$];
  exp_t       cur;
  logic       model_q = 0;
  bit         st1 = 0, st2 = 0, exp_mis = 0, saw_full = 0, acc;
  logic [7:0] exp_cnt = 0;

  jk_drive_ctrl #(.DEPTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_mode(cmd_mode), .cmd_a(cmd_a), .cmd_b(cmd_b), .J(J), .K(K),
    .q_fb(q_fb), .q_model(q_model), .busy(busy), .illegal_sr(illegal_sr),
    .mismatch(mismatch), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ff_q <= (J & ~ff_q) | (~K & ff_q);
  assign q_fb = stuck ? 1'b0 : ff_q;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic offer(input logic [1:0] m, input logic a, input logic b, output bit ok);
    exp_t e;
    cmd_mode = m; cmd_a = a; cmd_b = b; cmd_valid = 1;
    ok = cmd_ready;
    if (!ok) saw_full = 1;
    else begin
      e.ill = (m == 2'b01) && a && b;
      e.j   = a & ~e.ill;
      e.k   = (m == 2'b10) ? a : (m == 2'b11) ? ~a : b & ~e.ill;
      case ({e.j, e.k})
        2'b01:   model_q = 0;
        2'b10:   model_q = 1;
        2'b11:   model_q = ~model_q;
        default: model_q = model_q;
      endcase
      e.q = model_q;
      sb.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic send(input logic [1:0] m, input logic a, input logic b);
    bit ok = 0;
    for (int n = 0; n < 50 && !ok; n++) offer(m, a, b, ok);
    if (!ok) check("push_timeout", 0, 1);
  endtask

  task automatic drain();
    int n = 0;
    cmd_valid = 0;
    while ((sb.size() != 0 || busy) && n < 300) begin @(negedge clk); n++; end
    if (n >= 300) check("drain_timeout", 0, 1);
    repeat (3) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      st1 = 0; st2 = 0; exp_mis = 0; exp_cnt = 0;
    end else begin
      if (st1) begin
        check("q_model", q_model, cur.q);
        check("jk_one_cycle", {J, K}, 0);
        if (q_fb != cur.q) begin
          exp_mis = 1;
          if (exp_cnt != 8'hff) exp_cnt++;
        end
        st1 = 0; st2 = 1;
      end else if (st2) begin
        check("mismatch", mismatch, exp_mis);
        check("err_cnt", err_cnt, exp_cnt);
        st2 = 0;
      end
      if (J | K | illegal_sr) begin
        if (sb.size() == 0) check("unexpected_drive", {J, K, illegal_sr}, 0);
        else begin
          cur = sb.pop_front();
          check("jk_ill", {J, K, illegal_sr}, {cur.j, cur.k, cur.ill});
          st1 = 1;
        end
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_jk", {J, K}, 0);
    check("rst_q_model", q_model, 0);
    check("rst_flags", {illegal_sr, mismatch}, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_ready", cmd_ready, 1);
    check("rst_busy_sync", busy, 1);
    rst = 0;
    repeat (2) @(negedge clk);
    check("sync_idle", busy, 0);
    send(2'b11, 1, 0); send(2'b11, 0, 0); send(2'b11, 1, 0);
    drain();
    check("d_final_q", q_model, 1);
    repeat (4) send(2'b10, 1, 0);
    drain();
    check("t_final_q", q_model, 1);
    send(2'b01, 1, 1); send(2'b01, 0, 1);
    drain();
    check("sr_final_q", q_model, 0);
    for (int i = 0; i < 10; i++) begin
      logic [1:0] m = 2'($urandom_range(0, 3));
      logic a = 1'($urandom), b = 1'($urandom);
      if (m == 2'b10) a = 1;
      if (m[1] == 1'b0 && !a && !b) a = 1;
      offer(m, a, b, acc);
    end
    drain();
    check("saw_full", saw_full, 1);
    check("burst_no_mismatch", mismatch, 0);
    stuck = 1;
    send(2'b11, 1, 0);
    drain();
    check("stuck_err1", err_cnt, exp_cnt);
    for (int i = 0; i < 300; i++) send(2'b11, 1, 0);
    drain();
    check("err_sat", err_cnt, 255);
    check("mis_sticky", mismatch, 1);
    stuck = 0;
    rst = 1;
    @(negedge clk);
    rst = 0;
    model_q = ff_q;
    repeat (2) @(negedge clk);
    check("resync_q1", q_model, 1);
    check("rst_clears_err", {mismatch, err_cnt}, 0);
    send(2'b11, 0, 0);
    cmd_valid = 0;
    for (int n = 0; n < 20 && !K; n++) @(negedge clk);
    check("abort_reached_drive", K, 1);
    #1 rst = 1;
    #1 check("abort_jk", {J, K}, 0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 0;
    model_q = ff_q;
    repeat (2) @(negedge clk);
    check("abort_q_model", q_model, 1);
    send(2'b11, 0, 0); send(2'b11, 1, 0);
    drain();
    check("post_abort_mis", mismatch, 0);
    check("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
